// File: rtl/cla_pipe_pkg.sv
// Shared defaults and helpers for the pipelined carry-chained add/subtract unit.
package cla_pipe_pkg;

  localparam int CLA_PIPE_W_DEF = 64;
  localparam int CLA_PIPE_S_DEF = 4;

  // The carry into the MSB equals a^b^sum at that bit, so overflow needs no extra carry tap.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic cout);
    return (a_msb ^ b_msb ^ s_msb) ^ cout;
  endfunction

endpackage

// File: rtl/cla.sv
// Combinational segment adder: generate/propagate carry chain over one W-bit slice.
module cla
  import cla_pipe_pkg::*;
#(
  parameter int W = CLA_PIPE_W_DEF / CLA_PIPE_S_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s_o    = p ^ c[W-1:0];
  assign cout_o = c[W];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined add/subtract: one SW-bit segment resolved per stage, operands skewed in,
// partial results carried forward so every segment leaves the last register aligned.
module cla_pipe
  import cla_pipe_pkg::*;
#(
  parameter int W = CLA_PIPE_W_DEF,
  parameter int S = CLA_PIPE_S_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  input  logic         i_sub,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_y,
  output logic         o_cout,
  output logic         o_ovf
);

  localparam int SW = W / S;

  if ((S < 1) || (S > W) || ((W % S) != 0)) begin : g_cfg_err
    $error("cla_pipe: W must be a multiple of S and 1 <= S <= W");
  end

  logic         adv;
  logic [W-1:0] b_eff;
  logic         c0;

  // Global stall: every register advances together or not at all.
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;
  assign b_eff   = i_sub ? ~i_b : i_b;
  assign c0      = i_cin ^ i_sub;

  for (genvar k = 0; k < S; k++) begin : g_stg
    localparam int OPW = W - k*SW;
    localparam int YW  = (k+1)*SW;

    // op_a/op_b hold only the segments not yet consumed; segment k sits at the LSB.
    logic [OPW-1:0] op_a;
    logic [OPW-1:0] op_b;
    logic           c_in;
    logic           vld_in;
    logic [SW-1:0]  sum;
    logic           c_out;
    logic [YW-1:0]  y_res;

    if (k == 0) begin : g_src
      assign op_a   = i_a;
      assign op_b   = b_eff;
      assign c_in   = c0;
      assign vld_in = i_valid;
      assign y_res  = sum;
    end else begin : g_src
      logic [OPW-1:0]  a_q;
      logic [OPW-1:0]  b_q;
      logic [k*SW-1:0] y_q;
      logic            c_q;
      logic            vld_q;

      // Stage boundary k-1 -> k: pending operands, resolved low bits, carry, valid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          y_q   <= '0;
          c_q   <= 1'b0;
          vld_q <= 1'b0;
        end else if (adv) begin
          a_q   <= g_stg[k-1].op_a[OPW+SW-1:SW];
          b_q   <= g_stg[k-1].op_b[OPW+SW-1:SW];
          y_q   <= g_stg[k-1].y_res;
          c_q   <= g_stg[k-1].c_out;
          vld_q <= g_stg[k-1].vld_in;
        end
      end

      assign op_a   = a_q;
      assign op_b   = b_q;
      assign c_in   = c_q;
      assign vld_in = vld_q;
      assign y_res  = {sum, y_q};
    end

    cla #(.W(SW)) u_cla (
      .a_i   (op_a[SW-1:0]),
      .b_i   (op_b[SW-1:0]),
      .cin_i (c_in),
      .s_o   (sum),
      .cout_o(c_out)
    );
  end

  logic [W-1:0] y_q;
  logic         cout_q;
  logic         ovf_q;
  logic         vld_q;
  logic         ovf_d;

  assign ovf_d = signed_ovf(g_stg[S-1].op_a[SW-1], g_stg[S-1].op_b[SW-1],
                            g_stg[S-1].sum[SW-1], g_stg[S-1].c_out);

  // Last stage -> output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else if (adv) begin
      y_q    <= g_stg[S-1].y_res;
      cout_q <= g_stg[S-1].c_out;
      ovf_q  <= ovf_d;
      vld_q  <= g_stg[S-1].vld_in;
    end
  end

  assign o_y     = y_q;
  assign o_cout  = cout_q;
  assign o_ovf   = ovf_q;
  assign o_valid = vld_q;

endmodule
